// File: rtl/key_sched_seq_pkg.sv
// AES-128 key schedule shared definitions.
// Holds the round count, key/word widths, FSM state encoding, the Rcon
// table, the AES S-box and the RotWord byte rotation used by the
// key-expansion datapath.
package key_sched_seq_pkg;

    localparam int NR_DEFAULT = 10;
    localparam int KEY_W      = 128;
    localparam int WORD_W     = 32;
    localparam int IDX_W      = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GEN  = 1'b1
    } ks_state_e;

    // S-box packed with entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        return SBOX_TABLE[base -: 8];
    endfunction

    // (a0,a1,a2,a3) -> (a1,a2,a3,a0), a0 being the most significant byte.
    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Rcon[i] for i = 1..10; anything else yields 0.
    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_sched_seq_sub_word.sv
// SubWord: four parallel AES S-box lookups, purely combinational.
// Ports:
//   w   - input word
//   sw  - word with every byte substituted through the S-box
module key_sched_seq_sub_word
    import key_sched_seq_pkg::*;
(
    input  logic [31:0] w,
    output logic [31:0] sw
);

    assign sw = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};

endmodule

// File: rtl/key_sched_seq.sv
// Sequential AES-128 key expansion. One round key is presented per cycle
// on a valid/ready stream, starting with the cipher key itself (index 0)
// and ending with index NR.
//
// Handshake: a round key transfers on any cycle where rk_valid and
// rk_ready are both high. Once rk_valid is raised, round_key, round_idx
// and rk_valid hold until that transfer happens; rk_valid never depends
// on rk_ready.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begin expanding key_in (only honoured while idle)
//   key_in      - 128-bit cipher key, byte 0 in [127:120]
//   rk_ready    - downstream accepts round_key
//   rk_valid    - round_key / round_idx are valid
//   round_key   - words w[4i]..w[4i+3], w[4i] in [127:96]
//   round_idx   - index i of round_key, 0..NR
//   busy        - expansion in progress
//   done        - pulse on the cycle the index-NR key is accepted
//   state_dbg   - FSM state (0 = IDLE, 1 = GEN)
module key_sched_seq
    import key_sched_seq_pkg::*;
#(
    parameter int NR = NR_DEFAULT
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done,
    output logic         state_dbg
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

    ks_state_e state;

    logic              xfer;
    logic              last;
    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] rot, sw, t;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    assign xfer = rk_valid && rk_ready;
    assign last = (round_idx == LAST_IDX);

    // Combinational, so it falls as soon as reset clears rk_valid.
    assign done      = xfer && last;
    assign state_dbg = (state == ST_GEN);

    // Single combinational step from the current round key to the next.
    assign {w0, w1, w2, w3} = round_key;
    assign rot = rot_word(w3);

    key_sched_seq_sub_word u_sub_word (
        .w  (rot),
        .sw (sw)
    );

    assign t  = sw ^ {rcon(round_idx + 4'd1), 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            round_idx <= '0;
            round_key <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        round_idx <= '0;
                        rk_valid  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    if (xfer) begin
                        if (last) begin
                            // Key and index stay visible after the final key.
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            round_key <= {n0, n1, n2, n3};
                            round_idx <= round_idx + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_sched_seq.sv
module tb_key_sched_seq;

    localparam int NR = 10;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_ready = 1'b1;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;
    logic         state_dbg;

    always #5 clk = ~clk;

    key_sched_seq #(.NR(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- reference vectors ----------------
    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KF_KEY    = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    logic [127:0] fips_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // Only indices 0, 1 and 10 of this key are checked.
    logic [127:0] kf_rk [11] = '{
        128'h5468617473206d79204b756e67204675,
        128'he232fcf191129188b159e4e6d679a293,
        128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0,
        128'h28fddef86da4244accc0a4fe3b316f26
    };

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [127:0] exp_q[$];
    bit           chk_q[$];
    int           mon_idx  = 0;
    int           done_cnt = 0;
    logic [127:0] mon_key;
    bit           mon_chk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic push_exp(input bit use_fips);
        for (int i = 0; i <= NR; i++) begin
            if (use_fips) begin
                exp_q.push_back(fips_rk[i]);
                chk_q.push_back(1'b1);
            end else begin
                exp_q.push_back(kf_rk[i]);
                chk_q.push_back(i == 0 || i == 1 || i == NR);
            end
        end
    endtask

    // Monitor: every transfer is checked against the expected queue.
    always @(negedge clk) begin
        if (rst_n && rk_valid && rk_ready) begin
            check("exp_q_nonempty", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                mon_key = exp_q.pop_front();
                mon_chk = chk_q.pop_front();
                if (mon_chk) check("round_key", round_key, mon_key);
                check("round_idx", 128'(round_idx), 128'(mon_idx));
                check("done_on_xfer", 128'(done), 128'(mon_idx == NR));
                mon_idx = (mon_idx == NR) ? 0 : mon_idx + 1;
            end
        end else begin
            check("done_no_xfer", 128'(done), 128'd0);
        end
        if (done) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic start_key(input logic [127:0] k);
        @(posedge clk); #1;
        start  = 1'b1;
        key_in = k;
        @(posedge clk); #1;
        start  = 1'b0;
        check("start_valid", 128'(rk_valid), 128'd1);
        check("start_busy", 128'(busy), 128'd1);
        check("start_idx", 128'(round_idx), 128'd0);
        check("start_key", round_key, k);
        check("start_state", 128'(state_dbg), 128'd1);
    endtask

    task automatic run_exp(input logic [127:0] k, input bit use_fips,
                           input int stall_idx, input int restart_idx,
                           input int exp_cycles);
        int cyc;
        int stall_left;
        bit stalled;
        bit restarted;
        push_exp(use_fips);
        rk_ready = 1'b1;
        start_key(k);
        cyc = 0; stall_left = 0; stalled = 0; restarted = 0;
        while (busy && cyc < 200) begin
            start    = 1'b0;
            rk_ready = 1'b1;
            if (stall_left > 0) begin
                rk_ready = 1'b0;
                stall_left--;
            end else if (!stalled && int'(round_idx) == stall_idx) begin
                stalled    = 1'b1;
                rk_ready   = 1'b0;
                stall_left = 2;
            end
            if (!restarted && int'(round_idx) == restart_idx) begin
                restarted = 1'b1;
                start     = 1'b1;
                key_in    = OTHER_KEY;
            end
            if (!rk_ready) begin
                #1;
                check("stall_key", round_key, fips_rk[stall_idx]);
                check("stall_idx", 128'(round_idx), 128'(stall_idx));
                check("stall_valid", 128'(rk_valid), 128'd1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        rk_ready = 1'b1;
        check("exp_cycles", 128'(cyc), 128'(exp_cycles));
        check("end_busy", 128'(busy), 128'd0);
        check("end_valid", 128'(rk_valid), 128'd0);
        check("end_idx_hold", 128'(round_idx), 128'(NR));
        check("end_key_hold", round_key, use_fips ? fips_rk[NR] : kf_rk[NR]);
        check("end_q_empty", 128'(exp_q.size()), 128'd0);
        check("end_state", 128'(state_dbg), 128'd0);
    endtask

    // ---------------- test sequence ----------------
    int done_before;
    int cyc;

    initial begin
        // Reset state.
        #3;
        check("rst_valid", 128'(rk_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_idx", 128'(round_idx), 128'd0);
        check("rst_key", round_key, 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_state", 128'(state_dbg), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // FIPS-197 key at full throughput.
        done_before = done_cnt;
        run_exp(FIPS_KEY, 1'b1, -1, -1, 11);
        check("done_once_fips", 128'(done_cnt - done_before), 128'd1);

        // Second known key.
        run_exp(KF_KEY, 1'b0, -1, -1, 11);

        // Back-pressure for three cycles at index 4.
        run_exp(FIPS_KEY, 1'b1, 4, -1, 14);

        // Start pulse mid-expansion is ignored.
        run_exp(FIPS_KEY, 1'b1, -1, 5, 11);

        // Idle keeps the last key and stays invalid.
        @(posedge clk); #1;
        check("idle_valid", 128'(rk_valid), 128'd0);
        check("idle_key", round_key, fips_rk[NR]);

        // Asynchronous reset at index 7.
        push_exp(1'b1);
        start_key(FIPS_KEY);
        cyc = 0;
        while (int'(round_idx) != 7 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_reached_7", 128'(round_idx), 128'd7);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 128'(rk_valid), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_idx", 128'(round_idx), 128'd0);
        check("abort_key", round_key, 128'd0);
        check("abort_done", 128'(done), 128'd0);
        check("abort_state", 128'(state_dbg), 128'd0);
        exp_q.delete();
        chk_q.delete();
        mon_idx = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_abort_valid", 128'(rk_valid), 128'd0);
            check("post_abort_busy", 128'(busy), 128'd0);
        end
        run_exp(FIPS_KEY, 1'b1, -1, -1, 11);

        // start held high across the final transfer.
        done_before = done_cnt;
        push_exp(1'b1);
        push_exp(1'b0);
        key_in   = FIPS_KEY;
        rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        check("held_start_idx0", round_key, FIPS_KEY);
        cyc = 0;
        while (busy && cyc < 50) begin
            key_in = KF_KEY;
            @(posedge clk); #1;
            cyc++;
        end
        check("held_cycles", 128'(cyc), 128'd11);
        check("gap_busy", 128'(busy), 128'd0);
        check("gap_valid", 128'(rk_valid), 128'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_valid", 128'(rk_valid), 128'd1);
        check("restart_idx", 128'(round_idx), 128'd0);
        check("restart_key", round_key, KF_KEY);
        cyc = 0;
        while (busy && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("restart_done_busy", 128'(busy), 128'd0);
        check("done_twice", 128'(done_cnt - done_before), 128'd2);
        check("held_q_empty", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
